// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller.
// Holds the FSM state type, load/store funct3 encodings, byte-enable base
// masks, and the load lane-adjust helper.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } t_mem_state;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Byte-enable masks for an access at offset 0
    localparam logic [7:0] BE_BYTE  = 8'h01;
    localparam logic [7:0] BE_HALF  = 8'h03;
    localparam logic [7:0] BE_WORD  = 8'h0F;
    localparam logic [7:0] BE_DWORD = 8'hFF;

    // The load mux only selects within bits [31:0], so any sub-doubleword
    // load from the upper word gets its word swapped down.
    function automatic logic [63:0] load_lane_adjust(input logic [63:0] rdata,
                                                     input logic [2:0]  off,
                                                     input logic [2:0]  f3);
        if (off[2] && (f3[1:0] != 2'b11)) begin
            return {rdata[31:0], rdata[63:32]};
        end
        return rdata;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between execute, the controller and data memory.
// Signal names are from the controller's point of view (i_* into it, o_* out).
//   slave  : the controller side
//   master : execute + memory side (drives i_*, observes o_*)
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    // execute request
    logic                  i_req;
    logic                  i_we;
    logic [2:0]            i_func_3;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_store_data;
    logic                  o_stall;
    // memory handshake
    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [7:0]            o_mem_be;
    logic                  i_mem_ready;
    logic                  i_mem_valid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    // completion to the load mux / exception logic
    logic [DATA_WIDTH-1:0] o_data;
    logic [2:0]            o_addr_offset;
    logic [2:0]            o_func_3;
    logic                  o_load_done;
    logic                  o_store_done;
    logic                  o_store_addr_ma;
    logic                  o_store_illegal;

    modport slave (
        input  i_req, i_we, i_func_3, i_addr, i_store_data,
        input  i_mem_ready, i_mem_valid, i_mem_rdata,
        output o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output o_data, o_addr_offset, o_func_3,
        output o_load_done, o_store_done, o_store_addr_ma, o_store_illegal
    );

    modport master (
        output i_req, i_we, i_func_3, i_addr, i_store_data,
        output i_mem_ready, i_mem_valid, i_mem_rdata,
        input  o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  o_data, o_addr_offset, o_func_3,
        input  o_load_done, o_store_done, o_store_addr_ma, o_store_illegal
    );
endinterface

// File: rtl/mem_access_ctrl_store_align.sv
// Combinational store alignment: byte enables, lane-shifted write data and
// store legality (misaligned / illegal funct3). Loads always get all lanes.
//   i_we, i_func_3, i_off, i_store_data : request being accepted
//   o_be, o_wdata                       : memory-side enables and data
//   o_misaligned, o_illegal             : store rejection reasons
module mem_access_ctrl_store_align
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_we,
    input  logic [2:0]            i_func_3,
    input  logic [2:0]            i_off,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    output logic [7:0]            o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_misaligned,
    output logic                  o_illegal
);

    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        o_be         = BE_DWORD;
        o_misaligned = 1'b0;
        if (i_we) begin
            unique case (i_func_3[1:0])
                F3_SB[1:0]: o_be = BE_BYTE << i_off;
                F3_SH[1:0]: begin
                    o_be         = BE_HALF << i_off;
                    o_misaligned = i_off[0];
                end
                F3_SW[1:0]: begin
                    o_be         = BE_WORD << i_off;
                    o_misaligned = |i_off[1:0];
                end
                default: begin
                    o_be         = BE_DWORD;
                    o_misaligned = |i_off;
                end
            endcase
        end
    end

    assign o_wdata   = i_store_data << {i_off, 3'b000};
    assign o_illegal = i_we & i_func_3[2];

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller. Accepts one load/store from execute,
// runs a req/ready/valid handshake on 8-byte-aligned addresses, and returns
// lane-adjusted load data with its funct3/offset to the load mux.
//   i_clk, i_arst : clock, asynchronous active-high reset
//   bus (slave)   : execute request, memory handshake, completion outputs
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_arst,
    mem_access_ctrl_if.slave bus
);

    t_mem_state            state_q, state_d;
    logic [2:0]            func_3_q, func_3_d;
    logic [2:0]            off_q, off_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]            mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            addr_offset_q, addr_offset_d;
    logic [2:0]            ld_func_3_q, ld_func_3_d;
    logic                  store_ma_q, store_ma_d;
    logic                  store_illegal_q, store_illegal_d;

    logic                  mem_req;
    logic                  stall;
    logic                  rsp_take;

    logic [7:0]            sa_be;
    logic [DATA_WIDTH-1:0] sa_wdata;
    logic                  sa_misaligned;
    logic                  sa_illegal;

    mem_access_ctrl_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_store_align (
        .i_we         (bus.i_we),
        .i_func_3     (bus.i_func_3),
        .i_off        (bus.i_addr[2:0]),
        .i_store_data (bus.i_store_data),
        .o_be         (sa_be),
        .o_wdata      (sa_wdata),
        .o_misaligned (sa_misaligned),
        .o_illegal    (sa_illegal)
    );

    always_comb begin
        state_d         = state_q;
        func_3_d        = func_3_q;
        off_d           = off_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_be_d        = mem_be_q;
        data_d          = data_q;
        addr_offset_d   = addr_offset_q;
        ld_func_3_d     = ld_func_3_q;
        store_ma_d      = 1'b0;
        store_illegal_d = 1'b0;
        mem_req         = 1'b0;
        stall           = 1'b0;
        rsp_take        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    // Bus fields are registered here so they stay stable
                    // through REQ regardless of what execute does next.
                    func_3_d    = bus.i_func_3;
                    off_d       = bus.i_addr[2:0];
                    mem_we_d    = bus.i_we;
                    mem_addr_d  = {bus.i_addr[ADDR_WIDTH-1:3], 3'b000};
                    mem_wdata_d = sa_wdata;
                    mem_be_d    = sa_be;
                    if (sa_illegal) begin
                        store_illegal_d = 1'b1;
                    end else if (sa_misaligned) begin
                        store_ma_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        stall   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (bus.i_mem_ready) begin
                    if (bus.i_mem_valid) begin
                        rsp_take = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.i_mem_valid) begin
                    rsp_take = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;  // ST_DONE
        endcase

        // Load results only move on a load response; stores leave them alone.
        if (rsp_take && !mem_we_q) begin
            data_d        = load_lane_adjust(bus.i_mem_rdata, off_q, func_3_q);
            addr_offset_d = off_q;
            ld_func_3_d   = func_3_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge _d value. The data/bus registers are reset too
    // because their outputs must read as zero straight out of reset.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q         <= ST_IDLE;
            func_3_q        <= '0;
            off_q           <= '0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_be_q        <= '0;
            data_q          <= '0;
            addr_offset_q   <= '0;
            ld_func_3_q     <= '0;
            store_ma_q      <= 1'b0;
            store_illegal_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            func_3_q        <= func_3_d;
            off_q           <= off_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_be_q        <= mem_be_d;
            data_q          <= data_d;
            addr_offset_q   <= addr_offset_d;
            ld_func_3_q     <= ld_func_3_d;
            store_ma_q      <= store_ma_d;
            store_illegal_q <= store_illegal_d;
        end
    end

    assign bus.o_stall         = stall;
    assign bus.o_mem_req       = mem_req;
    assign bus.o_mem_we        = mem_we_q;
    assign bus.o_mem_addr      = mem_addr_q;
    assign bus.o_mem_wdata     = mem_wdata_q;
    assign bus.o_mem_be        = mem_be_q;
    assign bus.o_data          = data_q;
    assign bus.o_addr_offset   = addr_offset_q;
    assign bus.o_func_3        = ld_func_3_q;
    assign bus.o_load_done     = (state_q == ST_DONE) & ~mem_we_q;
    assign bus.o_store_done    = (state_q == ST_DONE) &  mem_we_q;
    assign bus.o_store_addr_ma = store_ma_q;
    assign bus.o_store_illegal = store_illegal_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scoreboard of expected completion
// events, pushed when a request is driven and popped by a monitor on pulses.
module tb_mem_access_ctrl;

    typedef enum int {EV_LOAD = 0, EV_STORE = 1, EV_MA = 2, EV_ILL = 3} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [63:0] data;
        logic [2:0]  off;
        logic [2:0]  f3;
    } exp_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t        sb[$];
    logic [63:0] last_data = '0;
    logic [2:0]  last_off  = '0;
    logic [2:0]  last_f3   = '0;

    mem_access_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus ();

    mem_access_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: any pulse must match the oldest expected event.
    exp_t e;
    int   obs_kind;
    always @(negedge clk) begin
        #2;
        if (!arst && (bus.o_load_done || bus.o_store_done ||
                      bus.o_store_addr_ma || bus.o_store_illegal)) begin
            check("one_pulse", 64'($countones({bus.o_load_done, bus.o_store_done,
                                               bus.o_store_addr_ma, bus.o_store_illegal})), 64'd1);
            check("pulse_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                obs_kind = bus.o_load_done ? EV_LOAD : bus.o_store_done ? EV_STORE :
                           bus.o_store_addr_ma ? EV_MA : EV_ILL;
                check("ev_kind", 64'(obs_kind), 64'(e.kind));
                if (e.kind == EV_LOAD) begin
                    last_data = e.data;
                    last_off  = e.off;
                    last_f3   = e.f3;
                end
                check("o_data", bus.o_data, last_data);
                check("o_addr_offset", 64'(bus.o_addr_offset), 64'(last_off));
                check("o_func_3", 64'(bus.o_func_3), 64'(last_f3));
            end
        end
    end

    task automatic idle_inputs();
        bus.i_req       = 1'b0;
        bus.i_mem_ready = 1'b0;
        bus.i_mem_valid = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] sdata);
        bus.i_req        = 1'b1;
        bus.i_we         = we;
        bus.i_func_3     = f3;
        bus.i_addr       = addr;
        bus.i_store_data = sdata;
    endtask

    // One issued transaction: ready after ready_wait extra REQ cycles, valid
    // on the valid_wait-th WAIT cycle (0 = together with ready).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] sdata, input int ready_wait, input int valid_wait,
                           input logic [63:0] rdata, input logic [63:0] exp_maddr,
                           input logic [7:0] exp_be, input logic [63:0] exp_wdata,
                           input logic [63:0] exp_data, input int exp_stalls);
        int   stalls = 0;
        exp_t x;
        @(negedge clk);
        drive_req(we, f3, addr, sdata);
        bus.i_mem_rdata = $urandom();
        x.kind = we ? EV_STORE : EV_LOAD;
        x.data = exp_data;
        x.off  = addr[2:0];
        x.f3   = f3;
        sb.push_back(x);
        #1;
        stalls += int'(bus.o_stall);
        check("idle_mem_req", 64'(bus.o_mem_req), 64'd0);
        for (int c = 0; c <= ready_wait; c++) begin
            @(negedge clk);
            idle_inputs();
            bus.i_addr = 64'hDEAD_0000_0000_0007;  // upstream moves on
            #1;
            stalls += int'(bus.o_stall);
            check("req_mem_req", 64'(bus.o_mem_req), 64'd1);
            check("req_mem_addr", bus.o_mem_addr, exp_maddr);
            check("req_mem_we", 64'(bus.o_mem_we), 64'(we));
            check("req_mem_be", 64'(bus.o_mem_be), 64'(exp_be));
            if (we) check("req_mem_wdata", bus.o_mem_wdata, exp_wdata);
            if (c == ready_wait) begin
                bus.i_mem_ready = 1'b1;
                if (valid_wait == 0) begin
                    bus.i_mem_valid = 1'b1;
                    bus.i_mem_rdata = rdata;
                end
            end
        end
        for (int v = 1; v <= valid_wait; v++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            stalls += int'(bus.o_stall);
            check("wait_mem_req", 64'(bus.o_mem_req), 64'd0);
            if (v == valid_wait) begin
                bus.i_mem_valid = 1'b1;
                bus.i_mem_rdata = rdata;
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("done_stall", 64'(bus.o_stall), 64'd0);
        check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    endtask

    // A store that must be rejected without touching memory.
    task automatic run_reject(input logic [2:0] f3, input logic [63:0] addr, input ev_kind_e kind);
        exp_t x;
        @(negedge clk);
        drive_req(1'b1, f3, addr, 64'h1234_5678_9ABC_DEF0);
        x.kind = kind;
        x.data = '0;
        x.off  = '0;
        x.f3   = '0;
        sb.push_back(x);
        #1;
        check("rej_stall", 64'(bus.o_stall), 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            check("rej_mem_req", 64'(bus.o_mem_req), 64'd0);
            check("rej_stall_after", 64'(bus.o_stall), 64'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_req"}, 64'(bus.o_mem_req), 64'd0);
        check({tag, "_stall"}, 64'(bus.o_stall), 64'd0);
        check({tag, "_mem_we"}, 64'(bus.o_mem_we), 64'd0);
        check({tag, "_mem_addr"}, bus.o_mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, bus.o_mem_wdata, 64'd0);
        check({tag, "_mem_be"}, 64'(bus.o_mem_be), 64'd0);
        check({tag, "_data"}, bus.o_data, 64'd0);
        check({tag, "_off_f3"}, 64'({bus.o_addr_offset, bus.o_func_3}), 64'd0);
        check({tag, "_pulses"}, 64'({bus.o_load_done, bus.o_store_done,
                                     bus.o_store_addr_ma, bus.o_store_illegal}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t x;
        idle_inputs();
        drive_req(1'b0, 3'b000, 64'd0, 64'd0);
        bus.i_req       = 1'b0;
        bus.i_mem_rdata = '0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;

        // LD 0x1000, ready first cycle, valid 3 cycles after the request
        run_txn(1'b0, 3'b011, 64'h1000, 64'h0, 0, 2, 64'h1122334455667788,
                64'h1000, 8'hFF, 64'h0, 64'h1122334455667788, 4);
        // LW 0x1004: upper word swapped down
        run_txn(1'b0, 3'b010, 64'h1004, 64'h0, 1, 1, 64'hAAAAAAAA_55555555,
                64'h1000, 8'hFF, 64'h0, 64'h55555555_AAAAAAAA, 4);
        // SB 0x2003, minimum latency
        run_txn(1'b1, 3'b000, 64'h2003, 64'hEE, 0, 0, 64'h0,
                64'h2000, 8'h08, 64'hEE000000, 64'h0, 2);
        // Rejected stores
        run_reject(3'b010, 64'h2002, EV_MA);
        run_reject(3'b001, 64'h4001, EV_MA);
        run_reject(3'b011, 64'h5004, EV_MA);
        run_reject(3'b101, 64'h6000, EV_ILL);
        // SD with ready held off 5 cycles
        run_txn(1'b1, 3'b011, 64'h5000, 64'h0123456789ABCDEF, 5, 1, 64'h0,
                64'h5000, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 8);
        // SH / SW in the upper lanes
        run_txn(1'b1, 3'b001, 64'h4006, 64'hBEEF, 0, 1, 64'h0,
                64'h4000, 8'hC0, 64'hBEEF000000000000, 64'h0, 3);
        run_txn(1'b1, 3'b010, 64'h4004, 64'hFFFFFFFF_DEADBEEF, 2, 0, 64'h0,
                64'h4000, 8'hF0, 64'hDEADBEEF00000000, 64'h0, 4);
        // LBU upper word swaps, LD at offset 4 does not
        run_txn(1'b0, 3'b100, 64'h3006, 64'h0, 0, 1, 64'h0102030405060708,
                64'h3000, 8'hFF, 64'h0, 64'h0506070801020304, 3);
        run_txn(1'b0, 3'b011, 64'h300C, 64'h0, 0, 0, 64'hCAFEF00DDEADBEEF,
                64'h3008, 8'hFF, 64'h0, 64'hCAFEF00DDEADBEEF, 2);

        // Stray valid while idle must not produce a pulse
        @(negedge clk);
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = 64'h5555;
        @(negedge clk);
        idle_inputs();
        #1;
        check("stray_valid_data", bus.o_data, 64'hCAFEF00DDEADBEEF);

        // Reset in WAIT abandons the load
        @(negedge clk);
        drive_req(1'b0, 3'b011, 64'h1008, 64'h0);
        x.kind = EV_LOAD;
        x.data = 64'h0;
        x.off  = 3'd0;
        x.f3   = 3'b011;
        sb.push_back(x);
        @(negedge clk);
        idle_inputs();
        bus.i_mem_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        check("pre_rst_stall", 64'(bus.o_stall), 64'd1);
        #2;
        arst = 1'b1;
        sb.delete();
        last_data = '0;
        last_off  = '0;
        last_f3   = '0;
        #1;
        check_outputs_zero("midrst");
        bus.i_mem_valid = 1'b1;
        @(negedge clk);
        #1;
        check_outputs_zero("inrst");
        idle_inputs();
        @(negedge clk);
        arst = 1'b0;

        run_txn(1'b0, 3'b011, 64'h7000, 64'h0, 0, 2, 64'h0F0E0D0C0B0A0908,
                64'h7000, 8'hFF, 64'h0, 64'h0F0E0D0C0B0A0908, 4);

        @(negedge clk);
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
